// File: rtl/alu_issue_stage.sv
// Decode/issue stage: turns a MIPS instruction plus register-read data into an
// ALU op/operand bundle and queues it in a small in-order buffer.
module alu_issue_stage #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  ctrl_o,
  output logic [31:0] src1_o,
  output logic [31:0] src2_o,
  output logic [4:0]  dst_o,
  output logic        wb_o,
  output logic        illegal_o
);

  localparam int AW = (BUF_DEPTH > 2) ? 2 : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_NOR   = 4'd3;
  localparam logic [3:0] OP_ADDU  = 4'd4;
  localparam logic [3:0] OP_SUBU  = 4'd5;
  localparam logic [3:0] OP_SLT   = 4'd6;
  localparam logic [3:0] OP_EQUAL = 4'd7;
  localparam logic [3:0] OP_SRA   = 4'd8;
  localparam logic [3:0] OP_SRAV  = 4'd9;
  localparam logic [3:0] OP_LUI   = 4'd10;
  localparam logic [3:0] OP_SLTU  = 4'd11;
  localparam logic [3:0] OP_ILL   = 4'd15;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dst;
    logic        wb;
    logic        illegal;
  } op_t;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  op_t         dec;

  assign opcode   = instr_i[31:26];
  assign funct    = instr_i[5:0];
  assign imm      = instr_i[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  always_comb begin
    dec = '0;
    case (opcode)
      6'h00: begin
        dec.src1 = rs_data_i;
        dec.src2 = rt_data_i;
        dec.dst  = instr_i[15:11];
        case (funct)
          6'h21: dec.ctrl = OP_ADDU;
          6'h23: dec.ctrl = OP_SUBU;
          6'h24: dec.ctrl = OP_AND;
          6'h25: dec.ctrl = OP_OR;
          6'h27: dec.ctrl = OP_NOR;
          6'h2A: dec.ctrl = OP_SLT;
          6'h2B: dec.ctrl = OP_SLTU;
          6'h07: dec.ctrl = OP_SRAV;
          6'h03: begin
            // shamt travels to the ALU inside src1[10:6]
            dec.ctrl = OP_SRA;
            dec.src1 = imm_zext;
          end
          default: begin
            dec         = '0;
            dec.ctrl    = OP_ILL;
            dec.illegal = 1'b1;
          end
        endcase
      end
      6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F: begin
        dec.src1 = rs_data_i;
        dec.dst  = instr_i[20:16];
        case (opcode)
          6'h09:   begin dec.ctrl = OP_ADDU; dec.src2 = imm_sext; end
          6'h0A:   begin dec.ctrl = OP_SLT;  dec.src2 = imm_sext; end
          6'h0B:   begin dec.ctrl = OP_SLTU; dec.src2 = imm_sext; end
          6'h0C:   begin dec.ctrl = OP_AND;  dec.src2 = imm_zext; end
          6'h0D:   begin dec.ctrl = OP_OR;   dec.src2 = imm_zext; end
          default: begin dec.ctrl = OP_LUI;  dec.src2 = imm_zext; end
        endcase
      end
      6'h04: begin
        dec.ctrl = OP_EQUAL;
        dec.src1 = rs_data_i;
        dec.src2 = rt_data_i;
      end
      default: begin
        dec.ctrl    = OP_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    // beq and illegal ops leave dst at 0, so this also clears their wb
    dec.wb = (dec.dst != 5'd0) & ~dec.illegal;
  end

  op_t           mem [BUF_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  op_t           head;

  assign out_valid_o = (count != '0);
  assign in_ready_o  = rst_n & ((count < DEPTH_C) | out_ready_i);
  assign push        = in_valid_i & in_ready_o & ~flush_i;
  assign pop         = out_valid_o & out_ready_i & ~flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head      = out_valid_o ? mem[rd_ptr] : '0;
  assign ctrl_o    = head.ctrl;
  assign src1_o    = head.src1;
  assign src2_o    = head.src2;
  assign dst_o     = head.dst;
  assign wb_o      = head.wb;
  assign illegal_o = head.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed steps followed by random traffic, all
// checked against a queue-based reference of the issue buffer.
module tb_alu_issue_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ctrl;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  dst;
  logic        wb;
  logic        illegal;

  int n_checks = 0;
  int n_fail   = 0;
  logic last_rdy;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dst;
    logic        wb;
    logic        illegal;
  } exp_t;

  exp_t q[$];

  alu_issue_stage #(.BUF_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .rs_data_i(rs_data), .rt_data_i(rt_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .ctrl_o(ctrl), .src1_o(src1), .src2_o(src2),
    .dst_o(dst), .wb_o(wb), .illegal_o(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference decode written as a lookup of the instruction's meaning.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                      input logic [31:0] rt);
    exp_t e;
    int op, fn, rd_idx, rt_idx;
    int unsigned imm, sx;
    op     = int'(ins >> 26);
    fn     = int'(ins & 32'h3F);
    rd_idx = int'((ins >> 11) & 32'h1F);
    rt_idx = int'((ins >> 16) & 32'h1F);
    imm    = ins & 32'hFFFF;
    sx     = (imm >= 32'h8000) ? (imm | 32'hFFFF0000) : imm;
    e = '0;
    e.ctrl = 4'd15;
    e.illegal = 1'b1;
    if (op == 0) begin
      e.illegal = 1'b0;
      e.src1 = rs; e.src2 = rt; e.dst = 5'(rd_idx);
      case (fn)
        'h21: e.ctrl = 4;  'h23: e.ctrl = 5;  'h24: e.ctrl = 0;
        'h25: e.ctrl = 1;  'h27: e.ctrl = 3;  'h2A: e.ctrl = 6;
        'h2B: e.ctrl = 11; 'h07: e.ctrl = 9;
        'h03: begin e.ctrl = 8; e.src1 = imm; end
        default: begin e = '0; e.ctrl = 4'd15; e.illegal = 1'b1; end
      endcase
    end else if (op inside {'h09, 'h0A, 'h0B, 'h0C, 'h0D, 'h0F}) begin
      e.illegal = 1'b0;
      e.src1 = rs; e.dst = 5'(rt_idx);
      e.src2 = (op inside {'h09, 'h0A, 'h0B}) ? sx : imm;
      e.ctrl = (op == 'h09) ? 4'd4 : (op == 'h0A) ? 4'd6 : (op == 'h0B) ? 4'd11 :
               (op == 'h0C) ? 4'd0 : (op == 'h0D) ? 4'd1 : 4'd10;
    end else if (op == 'h04) begin
      e.illegal = 1'b0;
      e.ctrl = 4'd7; e.src1 = rs; e.src2 = rt; e.dst = 5'd0;
    end
    e.wb = !e.illegal && e.dst != 0;
    return e;
  endfunction

  // One clock: check in_ready against the model, advance the model, check the head.
  task automatic cycle();
    bit rdy_exp, acc, pp;
    exp_t nd;
    #1;
    rdy_exp = rst_n && ((q.size() < DEPTH) || out_ready);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy_exp});
    last_rdy = in_ready;
    acc = in_valid && rdy_exp && !flush;
    pp  = (q.size() > 0) && out_ready && !flush;
    nd  = ref_decode(instr, rs_data, rt_data);
    @(posedge clk);
    #1;
    if (!rst_n || flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(nd);
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("ctrl", {28'b0, ctrl}, {28'b0, q[0].ctrl});
      chk("src1", src1, q[0].src1);
      chk("src2", src2, q[0].src2);
      chk("dst", {27'b0, dst}, {27'b0, q[0].dst});
      chk("wb", {31'b0, wb}, {31'b0, q[0].wb});
      chk("illegal", {31'b0, illegal}, {31'b0, q[0].illegal});
    end
  endtask

  task automatic push_op(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = 1'b1; instr = ins; rs_data = rs; rt_data = rt;
    cycle();
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [31:0] r;
    logic [5:0] fl [9];
    logic [5:0] ol [7];
    fl = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B, 6'h07, 6'h03};
    ol = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h04};
    sel = $urandom_range(0, 9);
    r = $urandom;
    if (sel < 3) r = {6'h00, r[25:6], fl[$urandom_range(0, 8)]};
    else if (sel < 8) r = {ol[$urandom_range(0, 6)], r[25:0]};
    return r;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = '0; rs_data = '0; rt_data = '0;

    // reset
    cycle();
    cycle();
    chk("rst_in_ready", {31'b0, last_rdy}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    chk("rst_ctrl", {28'b0, ctrl}, 32'd0);
    rst_n = 1'b1;

    // addu $3,$1,$2
    out_ready = 1'b1;
    push_op(32'h00221821, 32'd5, 32'd7);
    chk("t1_in_ready", {31'b0, last_rdy}, 32'd1);
    chk("t1_valid", {31'b0, out_valid}, 32'd1);
    chk("t1_ctrl", {28'b0, ctrl}, 32'd4);
    chk("t1_src1", src1, 32'd5);
    chk("t1_src2", src2, 32'd7);
    chk("t1_dst", {27'b0, dst}, 32'd3);
    chk("t1_wb", {31'b0, wb}, 32'd1);
    chk("t1_ill", {31'b0, illegal}, 32'd0);

    // immediates
    push_op(32'h2422FFFF, 32'd1, 32'd2);
    chk("addiu_src2", src2, 32'hFFFFFFFF);
    chk("addiu_ctrl", {28'b0, ctrl}, 32'd4);
    chk("addiu_dst", {27'b0, dst}, 32'd2);
    push_op(32'h3022FFFF, 32'd1, 32'd2);
    chk("andi_src2", src2, 32'h0000FFFF);
    chk("andi_ctrl", {28'b0, ctrl}, 32'd0);
    push_op(32'h3C021234, 32'd1, 32'd2);
    chk("lui_src2", src2, 32'h00001234);
    chk("lui_ctrl", {28'b0, ctrl}, 32'd10);
    chk("lui_dst", {27'b0, dst}, 32'd2);

    // sra $3,$2,4
    push_op(32'h00021903, 32'd0, 32'h80000000);
    chk("sra_ctrl", {28'b0, ctrl}, 32'd8);
    chk("sra_src1", src1, 32'h00001903);
    chk("sra_src2", src2, 32'h80000000);
    chk("sra_dst", {27'b0, dst}, 32'd3);
    in_valid = 1'b0;
    cycle();

    // backpressure: A, B accepted, C held
    out_ready = 1'b0;
    push_op(32'h00221821, 32'hA, 32'd1);
    push_op(32'h00221821, 32'hB, 32'd1);
    push_op(32'h00221821, 32'hC, 32'd1);
    chk("bp_full_ready", {31'b0, last_rdy}, 32'd0);
    chk("bp_hold_src1", src1, 32'hA);
    cycle();
    chk("bp_hold2_src1", src1, 32'hA);
    out_ready = 1'b1;
    cycle();
    chk("bp_pushpop_ready", {31'b0, last_rdy}, 32'd1);
    chk("bp_head_b", src1, 32'hB);
    in_valid = 1'b0;
    cycle();
    chk("bp_head_c", src1, 32'hC);
    cycle();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // flush with 2 buffered ops and a live input
    out_ready = 1'b0;
    push_op(32'h00221821, 32'h21, 32'd1);
    push_op(32'h00221821, 32'h22, 32'd1);
    flush = 1'b1;
    push_op(32'h00221821, 32'h23, 32'd1);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    push_op(32'h3422BEEF, 32'h24, 32'd1);
    chk("post_flush_valid", {31'b0, out_valid}, 32'd1);
    chk("post_flush_src2", src2, 32'h0000BEEF);
    chk("post_flush_ctrl", {28'b0, ctrl}, 32'd1);

    // illegal op in order
    out_ready = 1'b1;
    push_op(32'hFC000000, 32'h55, 32'h66);
    chk("ill_head_prev", src1, 32'h00000055 & 32'h0);
    chk("ill_ctrl", {28'b0, ctrl}, 32'd15);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_wb", {31'b0, wb}, 32'd0);

    // reset mid-stream
    out_ready = 1'b0;
    push_op(32'h00221821, 32'h31, 32'd1);
    push_op(32'h00221821, 32'h32, 32'd1);
    rst_n = 1'b0;
    cycle();
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("postrst_valid", {31'b0, out_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 30) == 0);
      rst_n     = ($urandom_range(0, 60) != 0);
      instr     = rand_instr();
      rs_data   = $urandom;
      rt_data   = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
